// File: rtl/guess_sequencer.sv
// Letter-guessing game sequencer: holds a 5-letter secret word, checks one guess
// per position over five cycles, then scores the guess as hits or as a mistake.
module guess_sequencer (
   input  logic        clk,
   input  logic        nRst,
   input  logic [39:0] word,
   input  logic        word_valid,
   input  logic [7:0]  letter,
   input  logic        guess_valid,
   output logic        guess_ready,
   output logic [4:0]  indexCorrect,
   output logic [2:0]  correct,
   output logic [2:0]  incorrect,
   output logic        mistake,
   output logic        dup,
   output logic        gameEnd_host,
   output logic        win,
   output logic        lose,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_PLAY, S_CHECK, S_UPDATE, S_WIN, S_LOSE
   } state_t;

   state_t      r_state, w_next;
   logic [39:0] r_word;
   logic [7:0]  r_letter;
   logic [25:0] r_used;
   logic [4:0]  r_hit;
   logic [2:0]  r_idx;
   logic [4:0]  r_mask;
   logic [2:0]  r_correct;
   logic [2:0]  r_incorrect;
   logic        r_mistake;
   logic        r_dup;

   logic        w_in_range;
   logic [4:0]  w_letter_off;
   logic [31:0] w_used32;
   logic        w_letter_ok;
   logic        w_accept;
   logic        w_reject;
   logic [7:0]  w_word_byte;
   logic        w_match;
   logic [4:0]  w_new_mask;
   logic [2:0]  w_new_incorrect;

   function automatic logic [2:0] popcount5(input logic [4:0] m);
      popcount5 = {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]}
                + {2'b00, m[3]} + {2'b00, m[4]};
   endfunction

   // Handshake: a guess transfers on a rising edge where guess_valid and
   // guess_ready are both high; guess_ready is high only in PLAY, so a request
   // seen in any other state is simply not taken (and gets no dup pulse).
   always_comb begin
      w_in_range      = (letter >= 8'h41) && (letter <= 8'h5A);
      w_letter_off    = letter[4:0] - 5'd1;
      w_used32        = {6'd0, r_used};
      w_letter_ok     = w_in_range && !w_used32[w_letter_off];
      w_accept        = (r_state == S_PLAY) && guess_valid && w_letter_ok;
      w_reject        = (r_state == S_PLAY) && guess_valid && !w_letter_ok;
      w_new_mask      = r_mask | r_hit;
      w_new_incorrect = (r_incorrect == 3'd6) ? 3'd6 : r_incorrect + 3'd1;
      case (r_idx)
         3'd4:    w_word_byte = r_word[39:32];
         3'd3:    w_word_byte = r_word[31:24];
         3'd2:    w_word_byte = r_word[23:16];
         3'd1:    w_word_byte = r_word[15:8];
         default: w_word_byte = r_word[7:0];
      endcase
      w_match = (w_word_byte == r_letter);
   end

   always_comb begin
      w_next = r_state;
      if (word_valid) begin
         w_next = S_PLAY;
      end else begin
         case (r_state)
            S_PLAY:   if (w_accept) w_next = S_CHECK;
            S_CHECK:  if (r_idx == 3'd0) w_next = S_UPDATE;
            S_UPDATE: begin
               if (w_new_mask == 5'b11111)                      w_next = S_WIN;
               else if (r_hit == 5'd0 && w_new_incorrect == 3'd6) w_next = S_LOSE;
               else                                             w_next = S_PLAY;
            end
            default:  w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (nRst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (nRst || word_valid) begin
         r_word      <= nRst ? 40'd0 : word;
         r_letter    <= 8'd0;
         r_used      <= 26'd0;
         r_hit       <= 5'd0;
         r_idx       <= 3'd0;
         r_mask      <= 5'd0;
         r_correct   <= 3'd0;
         r_incorrect <= 3'd0;
         r_mistake   <= 1'b0;
         r_dup       <= 1'b0;
      end else begin
         r_mistake <= 1'b0;
         r_dup     <= 1'b0;
         case (r_state)
            S_PLAY: begin
               if (w_accept) begin
                  r_letter <= letter;
                  r_used   <= r_used | (26'd1 << w_letter_off);
                  r_hit    <= 5'd0;
                  r_idx    <= 3'd4;
               end else if (w_reject) begin
                  r_dup <= 1'b1;
               end
            end
            S_CHECK: begin
               r_hit <= r_hit | ({4'd0, w_match} << r_idx);
               if (r_idx != 3'd0) r_idx <= r_idx - 3'd1;
            end
            S_UPDATE: begin
               if (r_hit != 5'd0) begin
                  r_mask    <= w_new_mask;
                  r_correct <= popcount5(w_new_mask);
               end else begin
                  r_incorrect <= w_new_incorrect;
                  r_mistake   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign guess_ready  = (r_state == S_PLAY);
   assign win          = (r_state == S_WIN);
   assign lose         = (r_state == S_LOSE);
   assign gameEnd_host = win || lose;
   assign indexCorrect = r_mask;
   assign correct      = r_correct;
   assign incorrect    = r_incorrect;
   assign mistake      = r_mistake;
   assign dup          = r_dup;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_guess_sequencer.sv
// Bench for guess_sequencer: scripted MOORE games from a vector table, reset and
// abort corner cases, then random games checked against a game-level model.
module tb_guess_sequencer;

   logic        clk;
   logic        nRst;
   logic [39:0] word;
   logic        word_valid;
   logic [7:0]  letter;
   logic        guess_valid;
   logic        guess_ready;
   logic [4:0]  indexCorrect;
   logic [2:0]  correct;
   logic [2:0]  incorrect;
   logic        mistake;
   logic        dup;
   logic        gameEnd_host;
   logic        win;
   logic        lose;
   logic [2:0]  o_dbg_state;

   guess_sequencer dut (
      .clk(clk), .nRst(nRst), .word(word), .word_valid(word_valid),
      .letter(letter), .guess_valid(guess_valid), .guess_ready(guess_ready),
      .indexCorrect(indexCorrect), .correct(correct), .incorrect(incorrect),
      .mistake(mistake), .dup(dup), .gameEnd_host(gameEnd_host),
      .win(win), .lose(lose), .o_dbg_state(o_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [39:0] MOORE = 40'h4D4F4F5245;
   localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WIN = 2, PH_LOSE = 3;

   int n_tests = 0;
   int n_fail  = 0;
   logic [16:0] exp_q[$];

   // game-level model
   logic [7:0]  m_word[5];
   logic [25:0] m_used;
   logic [4:0]  m_mask;
   logic [2:0]  m_inc;
   int          m_phase;

   logic [16:0] dut_vec;
   assign dut_vec = {guess_ready, indexCorrect, correct, incorrect, mistake, dup,
                     gameEnd_host, win, lose};

   typedef struct packed {
      logic       load;
      logic [7:0] l;
      logic [4:0] mask;
      logic [2:0] corr;
      logic [2:0] inc;
      logic       mis;
      logic       dp;
      logic       w;
      logic       lo;
   } vec_t;
   vec_t tbl[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] exp_vec(input logic rdy, input logic mis, input logic dp);
      logic ended;
      ended = (m_phase == PH_WIN) || (m_phase == PH_LOSE);
      return {rdy, m_mask, 3'($countones(m_mask)), m_inc, mis, dp, ended,
              m_phase == PH_WIN, m_phase == PH_LOSE};
   endfunction

   task automatic check_vec(input string name, input logic [16:0] e);
      logic [16:0] x;
      exp_q.push_back(e);
      x = exp_q.pop_front();
      n_tests++;
      if (dut_vec !== x) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (rdy,mask,corr,inc,mis,dup,end,win,lose)",
                  name, dut_vec, x);
      end
   endtask

   task automatic model_reset();
      m_used = '0; m_mask = '0; m_inc = '0; m_phase = PH_IDLE;
      for (int p = 0; p < 5; p++) m_word[p] = 8'h00;
   endtask

   // driver tasks
   task automatic do_reset();
      nRst = 1'b1;
      tick();
      tick();
      nRst = 1'b0;
      model_reset();
   endtask

   task automatic load_word(input logic [39:0] w);
      word = w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int p = 0; p < 5; p++) m_word[p] = w[p*8 +: 8];
      m_used = '0; m_mask = '0; m_inc = '0; m_phase = PH_PLAY;
      check_vec("load", exp_vec(1'b1, 1'b0, 1'b0));
   endtask

   task automatic do_guess(input logic [7:0] l, output logic saw_mis, output logic saw_dup);
      logic [4:0] hits;
      logic       legal;
      saw_mis = 1'b0;
      saw_dup = 1'b0;
      guess_valid = 1'b1;
      letter = l;
      tick();
      guess_valid = 1'b0;
      if (m_phase != PH_PLAY) begin
         saw_dup = dup;
         check_vec("ignored", exp_vec(1'b0, 1'b0, 1'b0));
         tick();
         check_vec("ignored_hold", exp_vec(1'b0, 1'b0, 1'b0));
         return;
      end
      legal = (l >= 8'h41) && (l <= 8'h5A);
      if (legal) legal = !m_used[int'(l) - 'h41];
      if (!legal) begin
         saw_dup = dup;
         check_vec("dup_pulse", exp_vec(1'b1, 1'b0, 1'b1));
         tick();
         check_vec("dup_clear", exp_vec(1'b1, 1'b0, 1'b0));
         return;
      end
      m_used[int'(l) - 'h41] = 1'b1;
      for (int p = 0; p < 5; p++) hits[p] = (m_word[p] == l);
      check_vec("busy_accept", exp_vec(1'b0, 1'b0, 1'b0));
      // Guess requests while busy must be ignored.
      for (int k = 0; k < 6; k++) begin
         guess_valid = 1'($urandom_range(0, 1));
         letter = 8'($urandom_range('h41, 'h5A));
         tick();
         if (k < 5) check_vec("busy", exp_vec(1'b0, 1'b0, 1'b0));
      end
      guess_valid = 1'b0;
      if (hits != 5'd0) begin
         m_mask = m_mask | hits;
         if (m_mask == 5'b11111) m_phase = PH_WIN;
      end else begin
         m_inc = (m_inc < 3'd6) ? m_inc + 3'd1 : 3'd6;
         if (m_inc == 3'd6) m_phase = PH_LOSE;
      end
      saw_mis = mistake;
      check_vec("update", exp_vec(m_phase == PH_PLAY, hits == 5'd0, 1'b0));
      tick();
      check_vec("post_update", exp_vec(m_phase == PH_PLAY, 1'b0, 1'b0));
   endtask

   initial begin
      logic mis, dp;
      logic [39:0] w;
      nRst = 1'b1; word = '0; word_valid = 1'b0; letter = '0; guess_valid = 1'b0;

      tbl[0]  = '{1'b1, 8'h50, 5'b00000, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 8'h4F, 5'b01100, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 8'h4F, 5'b01100, 3'd2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 8'h4D, 5'b11100, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 8'h52, 5'b11110, 3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 8'h45, 5'b11111, 3'd5, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'h41, 5'b11111, 3'd5, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 8'h61, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 8'h41, 5'b00000, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 8'h42, 5'b00000, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 8'h43, 5'b00000, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 8'h44, 5'b00000, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 8'h46, 5'b00000, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 8'h47, 5'b00000, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 8'h48, 5'b00000, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1};

      do_reset();
      check_vec("reset", exp_vec(1'b0, 1'b0, 1'b0));
      do_guess(8'h41, mis, dp);

      for (int i = 0; i < 15; i++) begin
         logic [16:0] got, want;
         if (tbl[i].load) load_word(MOORE);
         do_guess(tbl[i].l, mis, dp);
         got  = {indexCorrect, correct, incorrect, mis, dp, win, lose};
         want = {tbl[i].mask, tbl[i].corr, tbl[i].inc, tbl[i].mis, tbl[i].dp,
                 tbl[i].w, tbl[i].lo};
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL table[%0d]: got %b expected %b", i, got, want);
         end
      end

      // Reset on the third CHECK cycle, together with word_valid.
      load_word(MOORE);
      guess_valid = 1'b1; letter = 8'h4D;
      tick();
      guess_valid = 1'b0;
      tick();
      tick();
      nRst = 1'b1; word_valid = 1'b1; word = MOORE;
      tick();
      nRst = 1'b0; word_valid = 1'b0;
      model_reset();
      check_vec("reset_mid_check", exp_vec(1'b0, 1'b0, 1'b0));
      n_tests++;
      if (o_dbg_state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected 0", o_dbg_state);
      end
      tick();
      check_vec("idle_hold", exp_vec(1'b0, 1'b0, 1'b0));
      load_word(MOORE);
      do_guess(8'h61, mis, dp);

      // Reset during UPDATE of a wrong guess: no mistake pulse follows.
      guess_valid = 1'b1; letter = 8'h50;
      tick();
      guess_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      nRst = 1'b1;
      tick();
      nRst = 1'b0;
      model_reset();
      check_vec("reset_mid_update", exp_vec(1'b0, 1'b0, 1'b0));

      // word_valid mid-CHECK aborts the guess and clears the used letters.
      load_word(MOORE);
      do_guess(8'h4F, mis, dp);
      guess_valid = 1'b1; letter = 8'h4D;
      tick();
      guess_valid = 1'b0;
      tick();
      tick();
      load_word(MOORE);
      do_guess(8'h4D, mis, dp);
      do_guess(8'h4F, mis, dp);

      // Random games over a small alphabet so repeats and misses are common.
      for (int g = 0; g < 12; g++) begin
         for (int p = 0; p < 5; p++) w[p*8 +: 8] = 8'($urandom_range('h41, 'h48));
         load_word(w);
         for (int n = 0; n < 22; n++) do_guess(8'($urandom_range('h3F, 'h4A)), mis, dp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/guess_sequencer.md
GUESS_SEQUENCER -- requirements
Module: guess_sequencer

Interface
REQ-001: clk  input  1  system clock; all state changes on rising edge.
REQ-002: nRst  input  1  synchronous, active-high reset: asserted = 1, sampled on rising clk. The port keeps the codebase reset port name.
REQ-003: word  input  40  secret word, 5 ASCII letters; word[39:32] = position 4 (leftmost), word[7:0] = position 0.
REQ-004: word_valid  input  1  one-cycle pulse; capture word and start a new game.
REQ-005: letter  input  8  ASCII guess, sampled only when a guess is accepted.
REQ-006: guess_valid  input  1  guess request, sampled in PLAY only.
REQ-007: guess_ready  output  1  high exactly while state = PLAY.
REQ-008: indexCorrect  output  5  cumulative revealed-position mask; bit i = position i.
REQ-009: correct  output  3  popcount of indexCorrect, range 0-5.
REQ-010: incorrect  output  3  mistake count, range 0-6.
REQ-011: mistake  output  1  one-cycle pulse per wrong guess.
REQ-012: dup  output  1  one-cycle pulse when a repeated or illegal guess is rejected.
REQ-013: gameEnd_host  output  1  high in WIN or LOSE.
REQ-014: win  output  1  high in WIN.
REQ-015: lose  output  1  high in LOSE.

Function
REQ-016: States are IDLE, PLAY, CHECK, UPDATE, WIN and LOSE; the reset state is IDLE.
REQ-017: A word_valid pulse in any state latches word into word_q, clears all scoring state and the used-letter bitmap, and moves to PLAY on the next edge.
REQ-018: word_valid has priority over every other event, including a guess in progress, which is aborted.
REQ-019: A guess is accepted only when state = PLAY, guess_valid = 1 and letter is in 0x41-0x5A ('A'-'Z') and is not yet set in the 26-bit used-letter bitmap.
REQ-020: On acceptance, the block latches letter_q, sets the letter's used bit, clears hit_q, sets idx = 4 and moves to CHECK.
REQ-021: A guess_valid in PLAY whose letter is outside 'A'-'Z' or already used is dropped: dup = 1 for the following cycle, state stays PLAY, no counter changes.
REQ-022: guess_valid outside PLAY is ignored with no dup pulse.
REQ-023: CHECK takes one cycle per position, idx = 4, 3, 2, 1, 0: hit_q[idx] <= (word_q byte idx == letter_q); after idx = 0 the next state is UPDATE.
REQ-024: CHECK therefore lasts exactly 5 cycles.
REQ-025: UPDATE with hit_q != 0: indexCorrect <= indexCorrect | hit_q and correct <= popcount of the new mask.
REQ-026: UPDATE with hit_q == 0: incorrect <= incorrect + 1, saturating at 6, and mistake = 1 for exactly one cycle, coincident with the incremented count.
REQ-027: Exit from UPDATE goes to WIN if the new mask = 5'b11111, else to LOSE if the new incorrect = 6, else to PLAY.
REQ-028: Latency is 7 edges from the acceptance edge to updated outputs and guess_ready = 1: 1 edge accept, 5 edges CHECK, 1 edge UPDATE.
REQ-029: Repeated letters in the word (e.g. 'O' in MOORE) reveal all matching positions in a single guess; correct increases by the number of matches.
REQ-030: WIN and LOSE hold all outputs steady until word_valid or reset; guesses are ignored in both states.
REQ-031: In IDLE, guess_ready = 0 and scoring outputs are 0 until the first word_valid.
REQ-032: All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-033: When nRst = 1 at a rising edge: state = IDLE; word_q, letter_q, hit_q, idx and the bitmap are 0; indexCorrect = 0, correct = 0, incorrect = 0, mistake = 0, dup = 0, gameEnd_host = 0, win = 0, lose = 0, guess_ready = 0.
REQ-034: Reset asserted mid-CHECK or mid-UPDATE discards the guess with no mistake pulse, and has priority over word_valid.

Verification
REQ-035: Reset, then word_valid with word = "MOORE" (0x4D4F4F5245) -> next cycle guess_ready = 1 and all scoring outputs = 0.
REQ-036: Guess 'P' (0x50) -> 7 edges later incorrect = 1, a single-cycle mistake pulse, indexCorrect = 5'b00000, guess_ready = 1.
REQ-037: Guess 'O' -> indexCorrect = 5'b01100, correct = 2, no mistake pulse; guess 'O' again -> dup pulse one cycle later, outputs unchanged.
REQ-038: Guess M, O, R, E -> indexCorrect = 5'b11111, correct = 5, win = 1, gameEnd_host = 1, guess_ready = 0; a further guess 'A' is ignored.
REQ-039: Guess A, B, C, D, F, G -> incorrect = 6 after the sixth guess, six mistake pulses, lose = 1, gameEnd_host = 1; a seventh guess changes nothing.
REQ-040: Reset on the third CHECK cycle of guess 'M' -> next cycle everything is 0 and state = IDLE; word_valid followed by guess 0x61 ('a') -> dup pulse, no counter change.
